// File: rtl/stbus_pkg.sv
// Shared ST-bus transmit constants, types and bit-position helpers.
package stbus_pkg;

    localparam int         TS_PER_FRAME = 32;
    localparam int         BITS_PER_TS  = 8;
    localparam logic [7:0] IDLE_BYTE    = 8'hFF;

    localparam int TS_W  = $clog2(TS_PER_FRAME);
    localparam int BIT_W = $clog2(BITS_PER_TS);
    localparam int CNT_W = TS_W + BIT_W;

    typedef logic [TS_W-1:0]        ts_t;
    typedef logic [BIT_W-1:0]       bit_idx_t;
    typedef logic [CNT_W-1:0]       bit_cnt_t;
    typedef logic [BITS_PER_TS-1:0] byte_t;

    function automatic ts_t cnt_ts(input bit_cnt_t cnt);
        return ts_t'(cnt >> BIT_W);
    endfunction

    // Bit 0 of the count selects the byte MSB, so the line is sent MSB first.
    function automatic logic msb_first_bit(input byte_t data, input bit_idx_t pos);
        return data[bit_idx_t'(BITS_PER_TS - 1) - pos];
    endfunction

endpackage

// File: rtl/stx_bank_ram.sv
// Double-buffered 2x32-byte timeslot store: one bank transmits, the other takes host writes.
module stx_bank_ram
    import stbus_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  swap_i,
    input  logic  wr_en_i,
    input  ts_t   wr_addr_i,
    input  byte_t wr_data_i,
    input  ts_t   rd_addr_i,
    output byte_t rd_data_o
);

    logic  bank_sel_q;
    byte_t mem_q [2][TS_PER_FRAME];
    logic  rd_bank;
    logic  wr_bank;

    // Both ports see the banks as they stand after this edge's swap.
    assign rd_bank   = swap_i ? ~bank_sel_q : bank_sel_q;
    assign wr_bank   = ~rd_bank;
    assign rd_data_o = mem_q[rd_bank][rd_addr_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel_q <= 1'b0;
            // NOTE: the store is reset to idle so a restarted link never replays stale bytes.
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < TS_PER_FRAME; t++) begin
                    mem_q[b][t] <= IDLE_BYTE;
                end
            end
        end else begin
            if (swap_i) begin
                bank_sel_q <= ~bank_sel_q;
            end
            if (wr_en_i) begin
                mem_q[wr_bank][wr_addr_i] <= wr_data_i;
            end
        end
    end

endmodule

// File: rtl/stbus_tx_serializer.sv
// ST-bus transmit serializer: banked timeslot bytes shifted out MSB first on bit_en.
// Optional loss-of-frame detection is compiled in with `define STX_LOF_DETECT_EN.
module stbus_tx_serializer
    import stbus_pkg::*;
(
    input  logic       c4,
    input  logic       rst_n,
    input  logic       f0,
    input  logic       bit_en,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       dx,
    output logic [4:0] ts_num,
    output logic       frame_start
`ifdef STX_LOF_DETECT_EN
    ,
    output logic       lof
`endif
);

    logic     f0_q;
    logic     f0_accept;
    bit_cnt_t bit_cnt_q, bit_cnt_d;
    bit_cnt_t eff_cnt;
    logic     dx_q, dx_d;
    ts_t      ts_q, ts_d;
    logic     frame_start_q;
    byte_t    rd_byte;

    // Only the falling sample of f0 counts; a pulse held low stays a single frame start.
    assign f0_accept = ~f0 & f0_q;
    assign eff_cnt   = f0_accept ? '0 : bit_cnt_q;

    stx_bank_ram u_bank_ram (
        .clk       (c4),
        .rst_n     (rst_n),
        .swap_i    (f0_accept),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (cnt_ts(eff_cnt)),
        .rd_data_o (rd_byte)
    );

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no latch is inferred.
        bit_cnt_d = eff_cnt;
        dx_d      = dx_q;
        ts_d      = ts_q;
        if (bit_en) begin
            dx_d      = msb_first_bit(rd_byte, bit_idx_t'(eff_cnt));
            ts_d      = cnt_ts(eff_cnt);
            bit_cnt_d = eff_cnt + 1'b1;
        end
    end

    always_ff @(posedge c4 or negedge rst_n) begin
        if (!rst_n) begin
            f0_q          <= 1'b1;
            bit_cnt_q     <= '0;
            dx_q          <= 1'b1;
            ts_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            f0_q          <= f0;
            bit_cnt_q     <= bit_cnt_d;
            dx_q          <= dx_d;
            ts_q          <= ts_d;
            frame_start_q <= f0_accept;
        end
    end

    assign dx          = dx_q;
    assign ts_num      = ts_q;
    assign frame_start = frame_start_q;

`ifdef STX_LOF_DETECT_EN
    logic       wrap;
    logic [1:0] wrap_cnt_q, wrap_cnt_d;
    logic       lof_q;

    // A wrap is the count rolling past the last bit of timeslot 31 without a new frame.
    assign wrap = bit_en & ~f0_accept & (bit_cnt_q == '1);

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (f0_accept) begin
            wrap_cnt_d = 2'd0;
        end else if (wrap && (wrap_cnt_q != 2'd2)) begin
            wrap_cnt_d = wrap_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge c4 or negedge rst_n) begin
        if (!rst_n) begin
            wrap_cnt_q <= 2'd0;
            lof_q      <= 1'b0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
            lof_q      <= (wrap_cnt_d == 2'd2);
        end
    end

    assign lof = lof_q;
`endif

endmodule

// File: tb/tb_stbus_tx_serializer.sv
// Self-checking bench for stbus_tx_serializer: array-based frame model plus directed literal checks.
module tb_stbus_tx_serializer;

    logic       c4;
    logic       rst_n;
    logic       f0;
    logic       bit_en;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       dx;
    logic [4:0] ts_num;
    logic       frame_start;
`ifdef STX_LOF_DETECT_EN
    logic       lof;
`endif

    int checks   = 0;
    int failures = 0;

    stbus_tx_serializer dut (
        .c4          (c4),
        .rst_n       (rst_n),
        .f0          (f0),
        .bit_en      (bit_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .dx          (dx),
        .ts_num      (ts_num),
        .frame_start (frame_start)
`ifdef STX_LOF_DETECT_EN
        ,
        .lof         (lof)
`endif
    );

    initial begin
        c4 = 1'b0;
        forever #5 c4 = ~c4;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: two whole frames held as byte arrays, a linear bit position 0..255.
    logic [7:0] m_act [32];
    logic [7:0] m_ina [32];
    logic [7:0] m_tmp [32];
    int         m_pos;
    int         m_wraps;
    logic       m_f0_prev;
    logic       m_acc;
    logic       e_dx;
    logic [4:0] e_ts;
    logic       e_fs;
    logic       e_lof;

    always @(posedge c4 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_act[i] = 8'hFF;
                m_ina[i] = 8'hFF;
            end
            m_pos     = 0;
            m_wraps   = 0;
            m_f0_prev = 1'b1;
            e_dx      = 1'b1;
            e_ts      = 5'd0;
            e_fs      = 1'b0;
            e_lof     = 1'b0;
        end else begin
            m_acc     = (f0 == 1'b0) && m_f0_prev;
            m_f0_prev = f0;
            if (m_acc) begin
                m_tmp   = m_act;
                m_act   = m_ina;
                m_ina   = m_tmp;
                m_pos   = 0;
                m_wraps = 0;
            end
            if (wr_en) m_ina[wr_addr] = wr_data;
            if (bit_en) begin
                e_dx  = m_act[m_pos / 8][7 - (m_pos % 8)];
                e_ts  = 5'(m_pos / 8);
                m_pos = m_pos + 1;
                if (m_pos == 256) begin
                    m_pos   = 0;
                    m_wraps = m_wraps + 1;
                end
            end
            e_fs  = m_acc;
            e_lof = (m_wraps >= 2);
        end
    end

    always @(negedge c4) begin
        if (rst_n === 1'b1) begin
            check("model_dx", dx, e_dx);
            check("model_ts_num", ts_num, e_ts);
            check("model_frame_start", frame_start, e_fs);
`ifdef STX_LOF_DETECT_EN
            check("model_lof", lof, e_lof);
`endif
        end
    end

    task automatic cyc(input logic f, input logic be, input logic we,
                       input logic [4:0] a, input logic [7:0] d);
        f0      = f;
        bit_en  = be;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        @(posedge c4);
        #1;
        f0     = 1'b1;
        bit_en = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f0 = 1'b1; bit_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(posedge c4);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic frame_pulse();
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    // One bit_en followed by an idle cycle, i.e. bit_en on every second c4.
    task automatic send_bit(output logic b, output logic [4:0] t);
        cyc(1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
        b = dx;
        t = ts_num;
        idle(1);
    endtask

    task automatic send_byte(output logic [7:0] v);
        logic       b;
        logic [4:0] t;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            send_bit(b, t);
            v = {v[6:0], b};
        end
    endtask

    logic [7:0] rx [32];

    task automatic send_frame();
        logic [7:0] v;
        for (int i = 0; i < 32; i++) begin
            send_byte(v);
            rx[i] = v;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic       b;
        logic [4:0] t;
        logic [7:0] v;
        int         ones;
        int         ts_err;

        rst_n = 1'b0;
        f0 = 1'b1; bit_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Reset state, then an unwritten frame: all ones, timeslots in order.
        do_reset();
        check("reset_dx", dx, 1'b1);
        check("reset_ts_num", ts_num, 5'd0);
        check("reset_frame_start", frame_start, 1'b0);
        frame_pulse();
        check("f0_frame_start", frame_start, 1'b1);
        ones = 0;
        ts_err = 0;
        for (int k = 0; k < 256; k++) begin
            send_bit(b, t);
            if (b === 1'b1) ones++;
            if (t !== 5'(k / 8)) ts_err++;
        end
        check("idle_frame_ones", ones, 256);
        check("idle_frame_ts_order_errors", ts_err, 0);
        check("idle_frame_last_ts", ts_num, 5'd31);

        // First and last timeslot bytes, then free-run into a repeat of the same bank.
        do_reset();
        wr(5'd0, 8'hA5);
        wr(5'd31, 8'h3C);
        frame_pulse();
        send_frame();
        check("ts0_bits", rx[0], 8'hA5);
        check("ts31_bits", rx[31], 8'h3C);
        check("ts1_idle", rx[1], 8'hFF);
        send_byte(v);
        check("freerun_ts0_bits", v, 8'hA5);
        check("freerun_ts_num", ts_num, 5'd0);

        // f0 and bit_en on the same edge.
        do_reset();
        wr(5'd0, 8'h80);
        cyc(1'b0, 1'b1, 1'b0, 5'd0, 8'd0);
        check("same_edge_dx", dx, 1'b1);
        check("same_edge_frame_start", frame_start, 1'b1);
        check("same_edge_ts_num", ts_num, 5'd0);
        idle(1);
        check("same_edge_fs_drop", frame_start, 1'b0);
        send_bit(b, t);
        check("same_edge_next_bit", b, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(b, t);
        check("same_edge_ts0_end", t, 5'd0);
        send_bit(b, t);
        check("same_edge_ts1_start", t, 5'd1);

        // Write on the swap edge lands in the bank that is inactive after the swap.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 5'd5, 8'h00);
        send_frame();
        check("swap_write_not_this_frame", rx[5], 8'hFF);
        frame_pulse();
        send_frame();
        check("swap_write_next_frame", rx[5], 8'h00);
        check("swap_write_neighbour", rx[4], 8'hFF);

        // f0 held low for two cycles swaps only once.
        do_reset();
        wr(5'd0, 8'h00);
        frame_pulse();
        check("long_f0_first_pulse", frame_start, 1'b1);
        frame_pulse();
        check("long_f0_second_no_pulse", frame_start, 1'b0);
        send_frame();
        check("long_f0_single_swap", rx[0], 8'h00);

        // Reset mid-frame at timeslot 17 bit 3.
        do_reset();
        wr(5'd17, 8'h00);
        frame_pulse();
        for (int k = 0; k < 140; k++) send_bit(b, t);
        check("pre_reset_dx", dx, 1'b0);
        check("pre_reset_ts_num", ts_num, 5'd17);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_dx", dx, 1'b1);
        check("async_reset_ts_num", ts_num, 5'd0);
        check("async_reset_frame_start", frame_start, 1'b0);
        @(posedge c4);
        #1;
        rst_n = 1'b1;
        send_byte(v);
        check("post_reset_bank0_ts0", v, 8'hFF);
        frame_pulse();
        send_frame();
        check("post_reset_ts17_cleared", rx[17], 8'hFF);

`ifdef STX_LOF_DETECT_EN
        // Two frames without f0 raise loss-of-frame; the next f0 clears it.
        do_reset();
        frame_pulse();
        for (int k = 0; k < 511; k++) send_bit(b, t);
        check("lof_before_second_wrap", lof, 1'b0);
        send_bit(b, t);
        check("lof_after_second_wrap", lof, 1'b1);
        frame_pulse();
        check("lof_cleared_by_f0", lof, 1'b0);
`endif

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                5'($urandom_range(0, 31)),
                8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1,
                ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                5'($urandom_range(0, 31)),
                8'($urandom_range(0, 255)));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
